// File: rtl/pj_mem_pkg.sv
// rtl/pj_mem_pkg.sv - shared codes, encodings and state type for the pj memory controller
package pj_mem_pkg;

    localparam logic [1:0] ACK_NONE = 2'b00;
    localparam logic [1:0] ACK_OK   = 2'b01;
    localparam logic [1:0] ACK_ERR  = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int TYPE_WRITE_BIT  = 0;
    localparam int TYPE_SINGLE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } pj_state_e;

    // Reserved size falls through to a full word write.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/pj_mem_array.sv
// rtl/pj_mem_array.sv - word storage with byte-lane synchronous write and combinational read
module pj_mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pj_mem_ctl.sv
// rtl/pj_mem_ctl.sv - pj bus memory controller: wait states, single accesses, wrapping 4-beat line reads
// Optional macro PJ_MEM_ERR_EN: error ack for out-of-range addresses and reserved transfer size.
module pj_mem_ctl
    import pj_mem_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] pj_addr,
    input  logic [3:0]  pj_type,
    input  logic [1:0]  pj_size,
    input  logic [31:0] pj_data_out,
    input  logic        pj_tv,
    input  logic        pj_ale,
    output logic [1:0]  pj_ack,
    output logic [31:0] pj_data_in
);

    pj_state_e         state_q;
    logic [MEM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              single_q;
    logic              write_q;
    logic              err_q;
    logic [3:0]        wait_cnt_q;
    logic [1:0]        beat_cnt_q;
    logic [1:0]        ack_q;
    logic [31:0]       rdata_q;

    logic              accept_d;
    logic              err_d;
    logic              last_beat_d;
    logic              mem_we_d;
    logic [MEM_AW-1:0] beat_addr_d;
    logic [31:0]       mem_rdata;
    logic              unused_bits;

    assign accept_d = pj_tv && !pj_ale;

`ifdef PJ_MEM_ERR_EN
    assign err_d = (|pj_addr[29:MEM_AW]) || (pj_size == SIZE_RSVD);
`else
    assign err_d = 1'b0;
`endif

    assign unused_bits = ^{pj_type[3:2], pj_addr[29:MEM_AW]};

    // Critical word first: only the low two bits advance, wrapping inside the aligned line.
    assign beat_addr_d = {addr_q[MEM_AW-1:2], addr_q[1:0] + beat_cnt_q};
    assign last_beat_d = single_q || err_q || (beat_cnt_q == 2'd3);
    assign mem_we_d    = (state_q == ST_BEAT) && write_q && !err_q;

    pj_mem_array #(
        .AW (MEM_AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we_d),
        .be_i    (be_q),
        .addr_i  (beat_addr_d),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            single_q   <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
            ack_q      <= ACK_NONE;
            rdata_q    <= '0;
        end else begin
            ack_q   <= ACK_NONE;
            rdata_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        addr_q     <= pj_addr[MEM_AW-1:0];
                        wdata_q    <= pj_data_out;
                        be_q       <= size_to_be(pj_size);
                        single_q   <= pj_type[TYPE_SINGLE_BIT];
                        write_q    <= pj_type[TYPE_SINGLE_BIT] & pj_type[TYPE_WRITE_BIT];
                        err_q      <= err_d;
                        beat_cnt_q <= '0;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_BEAT;
                        end else begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_BEAT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_BEAT: begin
                    if (err_q) begin
                        ack_q <= ACK_ERR;
                    end else begin
                        ack_q   <= ACK_OK;
                        rdata_q <= write_q ? 32'd0 : mem_rdata;
                    end
                    if (last_beat_d) begin
                        state_q    <= ST_IDLE;
                        beat_cnt_q <= '0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 2'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pj_ack     = ack_q;
    assign pj_data_in = rdata_q;

endmodule

// File: tb/tb_pj_mem_ctl.sv
// tb/tb_pj_mem_ctl.sv - scoreboard bench for pj_mem_ctl (MEM_AW=10, WAIT_CYCLES=1)
module tb_pj_mem_ctl;

    localparam int AW = 10;
    localparam int W  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] pj_addr = '0;
    logic [3:0]  pj_type = '0;
    logic [1:0]  pj_size = '0;
    logic [31:0] pj_data_out = '0;
    logic        pj_tv = 1'b0;
    logic        pj_ale = 1'b1;
    logic [1:0]  pj_ack;
    logic [31:0] pj_data_in;

    pj_mem_ctl #(
        .MEM_AW      (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pj_addr     (pj_addr),
        .pj_type     (pj_type),
        .pj_size     (pj_size),
        .pj_data_out (pj_data_out),
        .pj_tv       (pj_tv),
        .pj_ale      (pj_ale),
        .pj_ack      (pj_ack),
        .pj_data_in  (pj_data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [1:0]  ack;
        logic [31:0] data;
    } beat_t;

    beat_t       sb[$];
    beat_t       cur;
    logic [31:0] model [2**AW];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Each negedge either retires the scheduled beat or expects a quiet bus.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].at <= cyc) begin
                cur = sb.pop_front();
                check("beat_cycle", 32'(cyc), 32'(cur.at));
                check("beat_ack", {30'd0, pj_ack}, {30'd0, cur.ack});
                check("beat_data", pj_data_in, cur.data);
            end else begin
                check("idle_ack", {30'd0, pj_ack}, 32'd0);
                check("idle_data", pj_data_in, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge showing the last expected beat.
    task automatic issue(input logic [29:0] a, input logic [3:0] t, input logic [1:0] s,
                         input logic [31:0] d, input bit hold_tv, input int rst_beat);
        int          c0;
        int          n;
        int          last;
        bit          err;
        logic [9:0]  idx;
        logic [31:0] mask;
        c0 = cyc;
        pj_addr = a; pj_type = t; pj_size = s; pj_data_out = d;
        pj_tv = 1'b1; pj_ale = 1'b0;
        err = 1'b0;
`ifdef PJ_MEM_ERR_EN
        err = (a[29:10] != 20'd0) || (s == 2'b11);
`endif
        n = (t[1] || err) ? 1 : 4;
        if (rst_beat >= 0 && rst_beat < n) n = rst_beat + 1;
        for (int k = 0; k < n; k++) begin
            idx = {a[9:2], a[1:0] + 2'(k)};
            if (err)
                sb.push_back('{at: c0 + 2 + W + k, ack: 2'b10, data: 32'd0});
            else if (t[1] && t[0])
                sb.push_back('{at: c0 + 2 + W + k, ack: 2'b01, data: 32'd0});
            else
                sb.push_back('{at: c0 + 2 + W + k, ack: 2'b01, data: model[idx]});
        end
        if (!err && t[1] && t[0]) begin
            mask = (s == 2'b00) ? 32'h0000_00FF : (s == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            model[a[9:0]] = (model[a[9:0]] & ~mask) | (d & mask);
        end
        last = c0 + 2 + W + n - 1;
        @(negedge clk);
        pj_ale = 1'b1; pj_tv = hold_tv;
        pj_addr = 30'($urandom); pj_type = 4'($urandom);
        pj_size = 2'($urandom); pj_data_out = $urandom;
        for (int g = 0; g < 64 && cyc < last; g++) @(negedge clk);
        pj_tv = 1'b0;
        if (rst_beat >= 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) model[i] = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_ack", {30'd0, pj_ack}, 32'd0);
        check("reset_data", pj_data_in, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        issue(30'h5, 4'b0011, 2'b10, 32'hDEAD_BEEF, 1'b1, -1);
        issue(30'h5, 4'b0010, 2'b10, 32'h0, 1'b1, -1);

        for (int i = 0; i < 4; i++) issue(30'(8 + i), 4'b0011, 2'b10, 32'(16 + i), 1'b1, -1);
        issue(30'hA, 4'b0000, 2'b10, 32'h0, 1'b1, -1);
        issue(30'h9, 4'b0001, 2'b10, 32'h0, 1'b0, -1);

        issue(30'h3, 4'b0011, 2'b10, 32'hFFFF_FFFF, 1'b1, -1);
        issue(30'h3, 4'b0011, 2'b00, 32'h5555_55AA, 1'b1, -1);
        issue(30'h3, 4'b0010, 2'b10, 32'h0, 1'b1, -1);
        issue(30'h3, 4'b0011, 2'b01, 32'hABCD_1234, 1'b1, -1);
        issue(30'h3, 4'b0010, 2'b10, 32'h0, 1'b1, -1);

        issue(30'h4, 4'b0011, 2'b11, 32'h0BAD_CAFE, 1'b1, -1);
        issue(30'h4, 4'b0010, 2'b10, 32'h0, 1'b1, -1);

        issue(30'h0, 4'b0011, 2'b10, 32'hCAFE_F00D, 1'b1, -1);
        issue(30'h400, 4'b0010, 2'b10, 32'h0, 1'b1, -1);

        issue(30'h8, 4'b0000, 2'b10, 32'h0, 1'b1, 1);
        issue(30'hB, 4'b0010, 2'b10, 32'h0, 1'b1, -1);

        for (int i = 0; i < 16; i++) issue(30'(32 + i), 4'b0011, 2'b10, $urandom, 1'b1, -1);
        for (int i = 0; i < 40; i++) begin
            issue({($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0, 10'(32 + $urandom_range(0, 15))},
                  4'($urandom), 2'($urandom), $urandom, 1'($urandom), -1);
        end

        repeat (6) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
